btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 153 +++++++++++++++
 tb/tb_btn_conditioner.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button conditioner: per-channel two-flop synchronizer, counter debounce and
// press / auto-repeat FSM, with press pulses cancelled when both channels of a pair fire together.
module btn_conditioner #(
  parameter int N_BTN         = 4,
  parameter int DEB_CYCLES    = 512,
  parameter int HOLD_CYCLES   = 5_000_000,
  parameter int REPEAT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic               any_held,
  output logic [2*N_BTN-1:0] fsm_state
);

  localparam int T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int DW    = $clog2(DEB_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] press_raw;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;

  logic [DW-1:0] deb_q   [N_BTN];
  logic [DW-1:0] deb_d   [N_BTN];
  logic [TW-1:0] tmr_q   [N_BTN];
  logic [TW-1:0] tmr_d   [N_BTN];
  state_t        state_q [N_BTN];
  state_t        state_d [N_BTN];

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      deb_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
    end
  end

  // Edges are taken from the next level so pulses line up with the level register.
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_comb begin
    press_raw = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      if (!ena) begin
        state_d[i] = IDLE;
        tmr_d[i]   = '0;
      end else if (fall[i]) begin
        state_d[i]   = IDLE;
        tmr_d[i]     = '0;
        release_d[i] = 1'b1;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              state_d[i]   = DELAY;
              tmr_d[i]     = '0;
              press_raw[i] = 1'b1;
            end
          end
          DELAY: begin
            if (tmr_q[i] == HOLD_LAST) begin
              state_d[i]   = REPEAT;
              tmr_d[i]     = '0;
              press_raw[i] = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (tmr_q[i] == REP_LAST) begin
              tmr_d[i]     = '0;
              press_raw[i] = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            tmr_d[i]   = '0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    assign press_d[i]           = press_raw[i] & ~press_raw[i ^ 1];
    assign fsm_state[2*i +: 2] = state_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_held    <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_q[i]   <= '0;
        tmr_q[i]   <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      any_held    <= |level_d;
      for (int i = 0; i < N_BTN; i++) begin
        deb_q[i]   <= deb_d[i];
        tmr_q[i]   <= tmr_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus randomized bouncing buttons,
// every cycle compared against a timing-rule model of levels, presses and releases.
module tb_btn_conditioner;

  localparam int N_BTN = 4;
  localparam int DEB   = 4;
  localparam int HOLD  = 10;
  localparam int REP   = 3;

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic               ena     = 1'b1;
  logic [N_BTN-1:0]   btn_raw = '0;
  logic [N_BTN-1:0]   btn_level;
  logic [N_BTN-1:0]   btn_press;
  logic [N_BTN-1:0]   btn_release;
  logic               any_held;
  logic [2*N_BTN-1:0] fsm_state;

  int errors = 0;
  int checks = 0;

  // Clock / reset
  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN        (N_BTN),
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_held   (any_held),
    .fsm_state  (fsm_state)
  );

  // Reference model: raw delayed two edges, level flips once the last DEB samples
  // all disagree with it, presses follow elapsed time since the accepted rise.
  logic [N_BTN-1:0] m_hist1   = '0;
  logic [N_BTN-1:0] m_hist2   = '0;
  logic [N_BTN-1:0] m_level   = '0;
  logic [N_BTN-1:0] m_press   = '0;
  logic [N_BTN-1:0] m_release = '0;
  logic [DEB-1:0]   m_win   [N_BTN];
  bit               m_armed [N_BTN];
  int               m_since [N_BTN];

  task automatic model_edge();
    logic [N_BTN-1:0] samp;
    logic [N_BTN-1:0] nl;
    logic [N_BTN-1:0] p;
    if (!rst_n) begin
      m_hist1   = '0;
      m_hist2   = '0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < N_BTN; i++) begin
        m_win[i]   = '0;
        m_armed[i] = 1'b0;
        m_since[i] = 0;
      end
    end else begin
      samp    = m_hist2;
      m_hist2 = m_hist1;
      m_hist1 = btn_raw;
      nl        = m_level;
      p         = '0;
      m_release = '0;
      for (int i = 0; i < N_BTN; i++) begin
        m_win[i] = {m_win[i][DEB-2:0], samp[i]};
        if (m_level[i] ? (m_win[i] == '0) : (m_win[i] == '1)) nl[i] = ~m_level[i];
      end
      for (int i = 0; i < N_BTN; i++) begin
        if (!ena) begin
          m_armed[i] = 1'b0;
        end else if (!nl[i] && m_level[i]) begin
          m_armed[i]   = 1'b0;
          m_release[i] = 1'b1;
        end else if (nl[i] && !m_level[i]) begin
          m_armed[i] = 1'b1;
          m_since[i] = 0;
          p[i]       = 1'b1;
        end else if (m_armed[i]) begin
          m_since[i]++;
          p[i] = (m_since[i] >= HOLD) && (((m_since[i] - HOLD) % REP) == 0);
        end
      end
      for (int i = 0; i < N_BTN; i++) m_press[i] = p[i] & ~p[i ^ 1];
      m_level = nl;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 32'(btn_level), 32'(m_level));
    chk("press", 32'(btn_press), 32'(m_press));
    chk("release", 32'(btn_release), 32'(m_release));
    chk("any_held", 32'(any_held), 32'(|m_level));
    chk("state_known", 32'($isunknown(fsm_state)), 32'd0);
  endtask

  int          first;
  int          first2;
  int          rel;
  int          npress;
  int          npress2;
  logic        acc;
  logic        acc2;
  logic [31:0] press_q [$];
  logic [31:0] exp_q   [$];
  int          dur     [N_BTN];

  initial begin
    // Reset state
    for (int k = 0; k < 3; k++) tick();
    chk("reset_zero", 32'({btn_level, btn_press, btn_release, any_held}), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Clean press on channel 0, then release before the hold time
    first = -1; first2 = -1; npress = 0;
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (btn_press[0]) begin npress++; if (first < 0) first = k; end
      if (btn_level[0] && first2 < 0) first2 = k;
    end
    chk("b_press_latency", 32'(first), 32'd6);
    chk("b_level_latency", 32'(first2), 32'd6);
    chk("b_press_count", 32'(npress), 32'd1);
    btn_raw[0] = 1'b0;
    rel = -1; npress = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_release[0] && rel < 0) rel = k;
      if (btn_press[0]) npress++;
    end
    chk("b_release_latency", 32'(rel), 32'd6);
    chk("b_no_press_after", 32'(npress), 32'd0);

    // Bouncing channel 1 never settles long enough
    acc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      btn_raw[1] = ((k >> 1) & 1) == 0;
      tick();
      acc = acc | btn_level[1] | btn_press[1] | btn_release[1];
    end
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc = acc | btn_level[1] | btn_press[1] | btn_release[1];
    end
    chk("c_glitch_quiet", 32'(acc), 32'd0);

    // Long hold on channel 0: auto-repeat, then release coinciding with a repeat expiry
    press_q.delete(); exp_q.delete();
    rel = -1;
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 47) btn_raw[0] = 1'b0;
      tick();
      if (btn_press[0]) press_q.push_back(32'(k));
      if (btn_release[0] && rel < 0) rel = k;
    end
    exp_q.push_back(32'd6);
    for (int o = HOLD; o < 46; o += REP) exp_q.push_back(32'(6 + o));
    chk("d_press_count", 32'(press_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk("d_press_at", (i < press_q.size()) ? press_q[i] : 32'hffff_ffff, exp_q[i]);
    chk("d_release_at", 32'(rel), 32'd52);

    // Paired channels 0/1 rise together, channel 2 alongside
    first = -1; acc = 1'b0; npress = 0; npress2 = 0; first2 = -1;
    btn_raw[2:0] = 3'b111;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (btn_level[1:0] == 2'b11 && first < 0) first = k;
      acc = acc | (btn_level[0] ^ btn_level[1]);
      if (btn_press[0] || btn_press[1]) npress++;
      if (btn_press[2]) begin npress2++; if (first2 < 0) first2 = k; end
    end
    chk("e_pair_level_at", 32'(first), 32'd6);
    chk("e_pair_level_skew", 32'(acc), 32'd0);
    chk("e_pair_press_count", 32'(npress), 32'd0);
    chk("e_ch2_first_press", 32'(first2), 32'd6);
    chk("e_ch2_press_count", 32'(npress2), 32'd6);
    btn_raw[2:0] = 3'b000;
    for (int k = 0; k < 12; k++) tick();

    // Reset while channel 2 is auto-repeating
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("f_reset_zero", 32'({btn_level, btn_press, btn_release, any_held}), 32'd0);
    rst_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_press[2] && first < 0) first = k;
    end
    chk("f_press_after_reset", 32'(first), 32'd6);
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // Disable during the hold delay on channel 3
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    ena = 1'b0;
    acc = 1'b0; acc2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      acc  = acc | btn_press[3] | btn_release[3];
      acc2 = acc2 & btn_level[3];
    end
    chk("g_no_pulse_disabled", 32'(acc), 32'd0);
    chk("g_level_kept", 32'(acc2), 32'd1);
    ena = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      acc = acc | btn_press[3];
    end
    chk("g_no_press_reenabled", 32'(acc), 32'd0);
    btn_raw[3] = 1'b0;
    rel = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (btn_release[3] && rel < 0) rel = k;
    end
    chk("g_release_at", 32'(rel), 32'd6);
    btn_raw[3] = 1'b1;
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (btn_press[3] && first < 0) first = k;
    end
    chk("g_fresh_press_at", 32'(first), 32'd6);
    btn_raw[3] = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // Randomized bouncing, holds, pair alignment, enable drops and resets
    for (int i = 0; i < N_BTN; i++) dur[i] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (dur[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB) : $urandom_range(DEB, 60);
          if (i == 0 && $urandom_range(0, 2) == 0) begin
            btn_raw[1] = btn_raw[0];
            dur[1]     = dur[0] + 1;
          end
        end else begin
          dur[i]--;
        end
      end
      ena   = ($urandom_range(0, 99) < 96);
      rst_n = ($urandom_range(0, 999) >= 3);
      tick();
    end
    btn_raw = '0;
    ena     = 1'b1;
    rst_n   = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
